// File: rtl/mmu_arbiter.sv
// mmu_arbiter: shares one byte-wide sync RAM port between IF fetch and MEM load/store.
// Latency: reads finish 5 cycles after acceptance (+1 DONE cycle for MEM), stores take 4 (+1 DONE).
// Backpressure: requests are levels; IF waits for a tag match, MEM holds req until o_MEM_done.
module mmu_arbiter #(
    parameter logic [31:0] INVALID_TAG = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_IF_req,
    input  logic [31:0] i_IF_addr,
    output logic        o_IF_busy,
    output logic [31:0] o_IF_addr,
    output logic [31:0] o_IF_inst,
    input  logic        i_MEM_req,
    input  logic        i_MEM_we,
    input  logic [31:0] i_MEM_addr,
    input  logic [31:0] i_MEM_wdata,
    input  logic [3:0]  i_MEM_mask,
    output logic        o_MEM_busy,
    output logic        o_MEM_done,
    output logic [31:0] o_MEM_rdata,
    output logic        o_RAM_en,
    output logic        o_RAM_wr,
    output logic [31:0] o_RAM_addr,
    output logic [7:0]  o_RAM_dout,
    input  logic [7:0]  i_RAM_din
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q;
    logic            tail_q;
    req_t            req_q;
    logic [3:0][7:0] byte_q;
    logic            reading;
    logic            if_miss;

    assign reading = (state_q == IF_RD) || (state_q == MEM_RD);
    assign if_miss = i_IF_req && (i_IF_addr != o_IF_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_MEM_req) begin
                    state_d = i_MEM_we ? MEM_WR : MEM_RD;
                end else if (if_miss) begin
                    state_d = IF_RD;
                end
            end
            IF_RD:   if (tail_q) state_d = IDLE;
            MEM_RD:  if (tail_q) state_d = DONE;
            MEM_WR:  if (cnt_q == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tail_q marks the extra read cycle that catches the last byte after issue stops
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            tail_q      <= 1'b0;
            req_q       <= '0;
            byte_q      <= '0;
            o_IF_addr   <= INVALID_TAG;
            o_IF_inst   <= 32'd0;
            o_MEM_rdata <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= 2'd0;
                    tail_q <= 1'b0;
                    if (i_MEM_req) begin
                        req_q <= '{addr: i_MEM_addr, wdata: i_MEM_wdata, mask: i_MEM_mask};
                        if (i_MEM_we) begin
                            o_IF_addr <= INVALID_TAG;
                        end
                    end else if (if_miss) begin
                        req_q <= '{addr: i_IF_addr, wdata: 32'd0, mask: 4'd0};
                    end
                end
                IF_RD, MEM_RD: begin
                    if (tail_q) begin
                        cnt_q  <= 2'd0;
                        tail_q <= 1'b0;
                        if (state_q == IF_RD) begin
                            o_IF_inst <= {byte_q[0], byte_q[1], byte_q[2], i_RAM_din};
                            o_IF_addr <= req_q.addr;
                        end else begin
                            o_MEM_rdata <= {i_RAM_din, byte_q[2], byte_q[1], byte_q[0]};
                        end
                    end else begin
                        if (cnt_q != 2'd0) begin
                            byte_q[cnt_q - 2'd1] <= i_RAM_din;
                        end
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            tail_q <= 1'b1;
                        end
                    end
                end
                MEM_WR: cnt_q <= cnt_q + 2'd1;
                default: begin
                    cnt_q  <= 2'd0;
                    tail_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_IF_busy  = (state_q != IDLE);
        o_MEM_busy = (state_q == MEM_RD) || (state_q == MEM_WR);
        o_MEM_done = (state_q == DONE);
        o_RAM_addr = req_q.addr + {30'd0, cnt_q};
        o_RAM_en   = (reading && !tail_q) || (state_q == MEM_WR);
        o_RAM_wr   = 1'b0;
        o_RAM_dout = 8'd0;
        if (state_q == MEM_WR) begin
            o_RAM_wr   = req_q.mask[cnt_q];
            o_RAM_dout = req_q.wdata[{cnt_q, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Bench for mmu_arbiter: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a transaction-schedule reference model.
module tb_mmu_arbiter;

    localparam logic [31:0] INV = 32'hFFFFFFFF;

    logic        clk;
    logic        rst;
    logic        i_IF_req;
    logic [31:0] i_IF_addr;
    logic        o_IF_busy;
    logic [31:0] o_IF_addr;
    logic [31:0] o_IF_inst;
    logic        i_MEM_req;
    logic        i_MEM_we;
    logic [31:0] i_MEM_addr;
    logic [31:0] i_MEM_wdata;
    logic [3:0]  i_MEM_mask;
    logic        o_MEM_busy;
    logic        o_MEM_done;
    logic [31:0] o_MEM_rdata;
    logic        o_RAM_en;
    logic        o_RAM_wr;
    logic [31:0] o_RAM_addr;
    logic [7:0]  o_RAM_dout;
    logic [7:0]  i_RAM_din;

    mmu_arbiter #(.INVALID_TAG(INV)) dut (
        .clk(clk), .rst(rst),
        .i_IF_req(i_IF_req), .i_IF_addr(i_IF_addr),
        .o_IF_busy(o_IF_busy), .o_IF_addr(o_IF_addr), .o_IF_inst(o_IF_inst),
        .i_MEM_req(i_MEM_req), .i_MEM_we(i_MEM_we), .i_MEM_addr(i_MEM_addr),
        .i_MEM_wdata(i_MEM_wdata), .i_MEM_mask(i_MEM_mask),
        .o_MEM_busy(o_MEM_busy), .o_MEM_done(o_MEM_done), .o_MEM_rdata(o_MEM_rdata),
        .o_RAM_en(o_RAM_en), .o_RAM_wr(o_RAM_wr), .o_RAM_addr(o_RAM_addr),
        .o_RAM_dout(o_RAM_dout), .i_RAM_din(i_RAM_din)
    );

    int checks   = 0;
    int failures = 0;
    bit model_on = 0;

    logic [7:0] ram     [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];

    typedef struct packed {
        bit          en;
        bit          wr;
        bit          chk_dout;
        bit          ifb;
        bit          memb;
        bit          done;
        logic [1:0]  post;   // 0 none, 1 memory byte write, 2 IF word update, 3 MEM rdata update
        logic [31:0] addr;
        logic [7:0]  dout;
        logic [31:0] pa;
        logic [7:0]  pd;
        logic [31:0] pw;
    } exp_t;

    exp_t        sched[$];
    logic [31:0] m_if_addr = INV;
    logic [31:0] m_if_inst = 32'd0;
    logic [31:0] m_rdata   = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] m(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    // Byte-wide synchronous RAM: address sampled during a cycle, data returned the next cycle
    initial begin : ram_proc
        logic        l_en, l_wr;
        logic [31:0] l_addr;
        logic [7:0]  l_dout;
        i_RAM_din = 8'd0;
        forever begin
            @(negedge clk);
            l_en = o_RAM_en; l_wr = o_RAM_wr; l_addr = o_RAM_addr; l_dout = o_RAM_dout;
            @(posedge clk);
            #1;
            if (l_en && l_wr) ram[l_addr] = l_dout;
            i_RAM_din = (l_en && !l_wr) ? ram_rd(l_addr) : 8'($urandom);
        end
    end

    // Reference model: on each accepted transaction, lay out the expected per-cycle outputs
    initial begin : model_proc
        exp_t        e;
        bit          was_idle;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (model_on) begin
                was_idle = (sched.size() == 0);
                e = was_idle ? '0 : sched.pop_front();
                chk("ram_en",  32'(o_RAM_en),   32'(e.en));
                chk("ram_wr",  32'(o_RAM_wr),   32'(e.wr));
                chk("if_busy", 32'(o_IF_busy),  32'(e.ifb));
                chk("mem_busy",32'(o_MEM_busy), 32'(e.memb));
                chk("mem_done",32'(o_MEM_done), 32'(e.done));
                if (e.en) chk("ram_addr", o_RAM_addr, e.addr);
                if (e.chk_dout) chk("ram_dout", 32'(o_RAM_dout), 32'(e.dout));
                chk("if_addr",   o_IF_addr,   m_if_addr);
                chk("if_inst",   o_IF_inst,   m_if_inst);
                chk("mem_rdata", o_MEM_rdata, m_rdata);
                case (e.post)
                    2'd1: ref_mem[e.pa] = e.pd;
                    2'd2: begin m_if_inst = e.pw; m_if_addr = e.pa; end
                    2'd3: m_rdata = e.pw;
                    default: ;
                endcase
                if (rst) begin
                    sched.delete();
                    m_if_addr = INV; m_if_inst = 32'd0; m_rdata = 32'd0;
                end else if (was_idle && i_MEM_req) begin
                    a = i_MEM_addr;
                    if (i_MEM_we) begin
                        m_if_addr = INV;
                        for (int k = 0; k < 4; k++) begin
                            e = '0;
                            e.en = 1; e.wr = i_MEM_mask[k]; e.chk_dout = 1;
                            e.addr = a + 32'(k); e.dout = i_MEM_wdata[8*k +: 8];
                            e.ifb = 1; e.memb = 1;
                            if (i_MEM_mask[k]) begin e.post = 2'd1; e.pa = e.addr; e.pd = e.dout; end
                            sched.push_back(e);
                        end
                    end else begin
                        for (int k = 0; k < 4; k++) begin
                            e = '0; e.en = 1; e.addr = a + 32'(k); e.ifb = 1; e.memb = 1;
                            sched.push_back(e);
                        end
                        e = '0; e.ifb = 1; e.memb = 1; e.post = 2'd3;
                        e.pw = {m(a + 32'd3), m(a + 32'd2), m(a + 32'd1), m(a)};
                        sched.push_back(e);
                    end
                    e = '0; e.ifb = 1; e.done = 1;
                    sched.push_back(e);
                end else if (was_idle && i_IF_req && (i_IF_addr !== m_if_addr)) begin
                    a = i_IF_addr;
                    for (int k = 0; k < 4; k++) begin
                        e = '0; e.en = 1; e.addr = a + 32'(k); e.ifb = 1;
                        sched.push_back(e);
                    end
                    e = '0; e.ifb = 1; e.post = 2'd2; e.pa = a;
                    e.pw = {m(a), m(a + 32'd1), m(a + 32'd2), m(a + 32'd3)};
                    sched.push_back(e);
                end
            end
        end
    end

    task automatic mem_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] mk, output logic [31:0] rd);
        bit got = 0;
        i_MEM_req = 1; i_MEM_we = we; i_MEM_addr = a; i_MEM_wdata = wd; i_MEM_mask = mk;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            if (o_MEM_done) begin got = 1; i_MEM_req = 0; end
        end
        chk("mem_op_done_in_time", 32'(got), 32'd1);
        i_MEM_req = 0;
        rd = o_MEM_rdata;
    endtask

    initial begin : stim
        logic [31:0] rd;
        bit          mem_active;
        rst = 1; i_IF_req = 0; i_IF_addr = 32'h0;
        i_MEM_req = 0; i_MEM_we = 0; i_MEM_addr = 0; i_MEM_wdata = 0; i_MEM_mask = 0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'h104, 8'h93); preload(32'h105, 8'h02); preload(32'h106, 8'h10); preload(32'h107, 8'h00);
        preload(32'h200, 8'h78); preload(32'h201, 8'h56); preload(32'h202, 8'h34); preload(32'h203, 8'h12);
        preload(32'h300, 8'h00); preload(32'h301, 8'h11); preload(32'h302, 8'h22); preload(32'h303, 8'h33);
        preload(32'hFFFFFFFE, 8'h01); preload(32'hFFFFFFFF, 8'h02);
        preload(32'h0, 8'h03); preload(32'h1, 8'h04);
        for (int k = 0; k < 4; k++) preload(32'h400 + 32'(k), 8'hAA);
        repeat (3) tick();
        chk("rst_if_addr", o_IF_addr, INV);
        chk("rst_if_inst", o_IF_inst, 32'd0);
        chk("rst_rdata",   o_MEM_rdata, 32'd0);
        chk("rst_flags",   {o_IF_busy, o_MEM_busy, o_MEM_done, o_RAM_en, o_RAM_wr}, 32'd0);
        chk("rst_dout",    32'(o_RAM_dout), 32'd0);
        model_on = 1;
        rst = 0;
        tick();

        // IF fetch of 0x100
        i_IF_req = 1; i_IF_addr = 32'h100;
        tick(); chk("fetch_c1_addr", o_RAM_addr, 32'h100);
        repeat (4) tick(); chk("fetch_c5_tag_not_yet", o_IF_addr, INV);
        tick();
        chk("fetch_c6_inst", o_IF_inst, 32'h13050000);
        chk("fetch_c6_tag",  o_IF_addr, 32'h100);
        repeat (3) tick(); chk("fetch_repeat_no_access", 32'(o_RAM_en | o_IF_busy), 32'd0);

        // MEM beats IF in the same idle cycle
        i_IF_addr = 32'h104;
        i_MEM_req = 1; i_MEM_we = 0; i_MEM_addr = 32'h200;
        repeat (6) tick();
        chk("prio_done_c6", 32'(o_MEM_done), 32'd1);
        chk("prio_rdata",   o_MEM_rdata, 32'h12345678);
        chk("prio_if_waits", o_IF_addr, 32'h100);
        i_MEM_req = 0;
        repeat (2) tick(); chk("prio_if_next_addr", o_RAM_addr, 32'h104);
        repeat (5) tick(); chk("prio_if_inst", o_IF_inst, 32'h93021000);
        chk("prio_if_tag", o_IF_addr, 32'h104);
        i_IF_req = 0;
        tick();

        // masked store
        i_MEM_req = 1; i_MEM_we = 1; i_MEM_addr = 32'h300; i_MEM_wdata = 32'hAABBCCDD; i_MEM_mask = 4'b0101;
        tick();
        chk("store_tag_invalid", o_IF_addr, INV);
        chk("store_b0", {o_RAM_wr, o_RAM_addr[15:0], o_RAM_dout}, {1'b1, 16'h0300, 8'hDD});
        tick(); chk("store_b1_nowr", 32'(o_RAM_wr), 32'd0);
        tick(); chk("store_b2", {o_RAM_wr, o_RAM_addr[15:0], o_RAM_dout}, {1'b1, 16'h0302, 8'hBB});
        tick(); chk("store_b3_nowr", 32'(o_RAM_wr), 32'd0);
        tick(); chk("store_done", 32'(o_MEM_done), 32'd1);
        i_MEM_req = 0;
        tick(); chk("store_done_one_cycle", 32'(o_MEM_done), 32'd0);
        mem_op(0, 32'h300, 32'd0, 4'd0, rd);
        chk("store_readback", rd, 32'h33BB11DD);
        tick();

        // wrap-around load
        i_MEM_req = 1; i_MEM_we = 0; i_MEM_addr = 32'hFFFFFFFE;
        tick(); chk("wrap_a0", o_RAM_addr, 32'hFFFFFFFE);
        tick(); chk("wrap_a1", o_RAM_addr, 32'hFFFFFFFF);
        tick(); chk("wrap_a2", o_RAM_addr, 32'h00000000);
        tick(); chk("wrap_a3", o_RAM_addr, 32'h00000001);
        repeat (2) tick(); chk("wrap_rdata", o_MEM_rdata, 32'h04030201);
        i_MEM_req = 0;
        tick();

        // reset in cycle 2 of a full store
        i_MEM_req = 1; i_MEM_we = 1; i_MEM_addr = 32'h400; i_MEM_wdata = 32'h01020304; i_MEM_mask = 4'hF;
        tick(); tick();
        rst = 1;
        tick();
        chk("rstmid_wr", 32'(o_RAM_wr), 32'd0);
        chk("rstmid_flags", {o_IF_busy, o_MEM_busy, o_MEM_done, o_RAM_en}, 32'd0);
        chk("rstmid_regs", o_IF_addr ^ INV ^ o_IF_inst ^ o_MEM_rdata, 32'd0);
        rst = 0; i_MEM_req = 0;
        tick();
        mem_op(0, 32'h400, 32'd0, 4'd0, rd);
        chk("rstmid_partial_write", rd, 32'hAAAA0304);
        tick();

        // request held high through DONE
        i_MEM_req = 1; i_MEM_we = 0; i_MEM_addr = 32'h200;
        repeat (6) tick();
        chk("held_done", {o_MEM_done, o_MEM_busy}, 32'b10);
        tick(); chk("held_idle_gap", {o_MEM_done, o_MEM_busy, o_IF_busy}, 32'd0);
        tick(); chk("held_second_accept", 32'(o_MEM_busy), 32'd1);
        mem_op(0, 32'h200, 32'd0, 4'd0, rd);
        chk("held_second_rdata", rd, 32'h12345678);

        // randomized traffic
        mem_active = 0;
        for (int c = 0; c < 3000; c++) begin
            if (mem_active && o_MEM_done) begin
                if ($urandom_range(0, 7) != 0) begin i_MEM_req = 0; mem_active = 0; end
            end else if (!mem_active && $urandom_range(0, 3) == 0) begin
                mem_active = 1;
                i_MEM_req = 1;
                i_MEM_we = 1'($urandom_range(0, 1));
                i_MEM_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                         : 32'h100 + 32'($urandom_range(0, 31));
                i_MEM_wdata = $urandom;
                i_MEM_mask = 4'($urandom_range(0, 15));
            end
            i_IF_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                i_IF_addr = ($urandom_range(0, 8) == 8) ? 32'hFFFFFFFC : 32'h100 + 32'(4 * $urandom_range(0, 7));
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0; i_MEM_req = 0; i_IF_req = 0;
        repeat (20) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
